// File: rtl/dmi_bus_bridge.sv
// DMI-to-register-bus bridge: accepts one DMI request at a time, runs at most one bus access,
// and reports SUCCESS/FAILED/BUSY back to the DTM. Bus waits are bounded by TIMEOUT cycles.

package jtag_dmi_pkg;
  parameter int unsigned DMI_ADDR_WIDTH = 7;
  parameter int unsigned DMI_DATA_WIDTH = 32;
endpackage

module dmi_bus_bridge
  import jtag_dmi_pkg::*;
#(
  parameter int unsigned ADDR_W  = DMI_ADDR_WIDTH,
  parameter int unsigned DATA_W  = DMI_DATA_WIDTH,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] dmi_addr,
  input  logic [DATA_W-1:0] dmi_wdata,
  input  logic [1:0]        dmi_op,
  input  logic              dmi_req_valid,
  output logic              dmi_req_ready,
  output logic [DATA_W-1:0] dmi_rdata,
  output logic [1:0]        dmi_resp,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err
);

  localparam logic [1:0] OpNop   = 2'd0;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] OpRsvd  = 2'd3;

  localparam logic [1:0] RespOk   = 2'd0;
  localparam logic [1:0] RespFail = 2'd2;
  localparam logic [1:0] RespBusy = 2'd3;

  localparam int unsigned CntW   = 16;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic {StIdle, StBus} state_e;

  state_e            state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        result_q, result_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    result_d    = result_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (dmi_req_valid) begin
          unique case (dmi_op)
            OpNop:  result_d = RespOk;
            OpRsvd: result_d = RespFail;
            OpRead, OpWrite: begin
              state_d     = StBus;
              bus_req_d   = 1'b1;
              bus_we_d    = (dmi_op == OpWrite);
              bus_addr_d  = dmi_addr;
              bus_wdata_d = dmi_wdata;
              cnt_d       = '0;
            end
            default: ;
          endcase
        end
      end
      StBus: begin
        // Ack wins over a timeout expiring in the same cycle.
        if (bus_ack) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          result_d  = bus_err ? RespFail : RespOk;
          if (!bus_we_q && !bus_err) rdata_d = bus_rdata;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
          result_d  = RespFail;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      result_q    <= RespOk;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      result_q    <= result_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dmi_req_ready = (state_q == StIdle);
  assign dmi_resp      = (state_q == StBus) ? RespBusy : result_q;
  assign dmi_rdata     = rdata_q;
  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;

endmodule

// File: tb/tb_dmi_bus_bridge.sv
// Scoreboard bench for dmi_bus_bridge: the driver queues expected DMI responses and bus
// transactions; independent monitors pop and compare when the DUT presents them.

module tb_dmi_bus_bridge;
  localparam int AW = 7;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] dmi_addr;
  logic [DW-1:0] dmi_wdata;
  logic [1:0]    dmi_op;
  logic          dmi_req_valid;
  logic          dmi_req_ready;
  logic [DW-1:0] dmi_rdata;
  logic [1:0]    dmi_resp;
  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;
  logic          bus_err;

  dmi_bus_bridge #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dmi_addr     (dmi_addr),
    .dmi_wdata    (dmi_wdata),
    .dmi_op       (dmi_op),
    .dmi_req_valid(dmi_req_valid),
    .dmi_req_ready(dmi_req_ready),
    .dmi_rdata    (dmi_rdata),
    .dmi_resp     (dmi_resp),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] rdata;
  } resp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            len;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  int    total = 0;
  int    bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout/unexpected event expected normal progress", name);
  endtask

  // Response monitor: after an accepted request, expect BUSY until ready returns.
  logic await_resp = 1'b0;
  always @(posedge clk) begin
    if (rst_n && dmi_req_valid && dmi_req_ready) await_resp = 1'b1;
  end

  always @(negedge clk) begin
    resp_t e;
    if (await_resp) begin
      if (dmi_req_ready) begin
        await_resp = 1'b0;
        if (resp_q.size() == 0) fail_now("resp_unexpected");
        else begin
          e = resp_q.pop_front();
          check("dmi_resp", 64'(dmi_resp), 64'(e.resp));
          check("dmi_rdata", 64'(dmi_rdata), 64'(e.rdata));
        end
      end else begin
        check("busy_resp", 64'(dmi_resp), 64'd3);
      end
    end
  end

  // Bus monitor: measures each bus_req pulse and its address/data fields.
  logic          in_acc = 1'b0;
  logic          unstable = 1'b0;
  logic          cur_we;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  int            cur_len = 0;

  always @(negedge clk) begin
    bus_t e;
    if (bus_req === 1'b1) begin
      if (!in_acc) begin
        in_acc    = 1'b1;
        unstable  = 1'b0;
        cur_we    = bus_we;
        cur_addr  = bus_addr;
        cur_wdata = bus_wdata;
        cur_len   = 1;
      end else begin
        cur_len++;
        if (bus_we !== cur_we || bus_addr !== cur_addr || bus_wdata !== cur_wdata)
          unstable = 1'b1;
      end
    end else if (in_acc) begin
      in_acc = 1'b0;
      if (bus_q.size() == 0) fail_now("bus_unexpected");
      else begin
        e = bus_q.pop_front();
        check("bus_we", 64'(cur_we), 64'(e.we));
        check("bus_addr", 64'(cur_addr), 64'(e.addr));
        check("bus_wdata", 64'(cur_wdata), 64'(e.wdata));
        check("bus_len", 64'(cur_len), 64'(e.len));
        check("bus_stable", 64'(unstable), 64'd0);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!dmi_req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!dmi_req_ready) fail_now(name);
  endtask

  task automatic push_bus(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int len);
    bus_t b;
    b.we    = we;
    b.addr  = a;
    b.wdata = d;
    b.len   = len;
    bus_q.push_back(b);
  endtask

  // ack_dly > 0: ack sampled on the ack_dly-th edge after acceptance; ack_dly <= 0: never ack.
  task automatic do_req(input logic [1:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input int ack_dly,
                        input logic [DW-1:0] rd, input logic err,
                        input logic [1:0] exp_resp, input logic [DW-1:0] exp_rdata);
    resp_t r;
    wait_ready("ready_before_req");
    r.resp  = exp_resp;
    r.rdata = exp_rdata;
    resp_q.push_back(r);
    if (op == 2'd1 || op == 2'd2) push_bus(op == 2'd2, addr, wdata, (ack_dly > 0) ? ack_dly : TO);
    dmi_op        = op;
    dmi_addr      = addr;
    dmi_wdata     = wdata;
    dmi_req_valid = 1'b1;
    @(posedge clk);
    #1;
    dmi_req_valid = 1'b0;
    dmi_addr      = ~addr;
    dmi_wdata     = ~wdata;
    dmi_op        = ~op;
    if (op == 2'd1 || op == 2'd2) begin
      if (ack_dly > 0) begin
        for (int i = 1; i < ack_dly; i++) begin
          @(posedge clk);
          #1;
        end
        bus_ack   = 1'b1;
        bus_rdata = rd;
        bus_err   = err;
        @(posedge clk);
        #1;
        bus_ack   = 1'b0;
        bus_err   = 1'b0;
        bus_rdata = 32'h0BAD0BAD;
      end else begin
        wait_ready("ready_after_timeout");
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resp_t r;
    rst_n         = 1'b0;
    dmi_addr      = '0;
    dmi_wdata     = '0;
    dmi_op        = '0;
    dmi_req_valid = 1'b0;
    bus_ack       = 1'b0;
    bus_rdata     = '0;
    bus_err       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(dmi_req_ready), 64'd1);
    check("rst_resp", 64'(dmi_resp), 64'd0);
    check("rst_rdata", 64'(dmi_rdata), 64'd0);
    check("rst_bus_req", 64'(bus_req), 64'd0);
    check("rst_bus_we", 64'(bus_we), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    check("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    do_req(2'd1, 7'h11, 32'h0, 3, 32'hDEADBEEF, 1'b0, 2'd0, 32'hDEADBEEF);
    do_req(2'd2, 7'h10, 32'h80000001, 1, 32'h0, 1'b0, 2'd0, 32'hDEADBEEF);
    do_req(2'd1, 7'h05, 32'h0, 0, 32'h0, 1'b0, 2'd2, 32'hDEADBEEF);
    do_req(2'd1, 7'h22, 32'h0, 2, 32'h12345678, 1'b1, 2'd2, 32'hDEADBEEF);

    // Stray ack with no access outstanding must change nothing.
    bus_ack   = 1'b1;
    bus_err   = 1'b0;
    bus_rdata = 32'hBADBAD00;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    check("stray_ack_resp", 64'(dmi_resp), 64'd2);
    check("stray_ack_rdata", 64'(dmi_rdata), 64'hDEADBEEF);

    do_req(2'd0, 7'h01, 32'h0, 0, 32'h0, 1'b0, 2'd0, 32'hDEADBEEF);
    do_req(2'd3, 7'h02, 32'h0, 0, 32'h0, 1'b0, 2'd2, 32'hDEADBEEF);
    do_req(2'd1, 7'h40, 32'h0, TO, 32'hCAFEF00D, 1'b0, 2'd0, 32'hCAFEF00D);
    do_req(2'd2, 7'h7F, 32'hA5A5A5A5, 2, 32'h0, 1'b1, 2'd2, 32'hCAFEF00D);
    do_req(2'd1, 7'h01, 32'h0, 1, 32'h00001111, 1'b0, 2'd0, 32'h00001111);
    do_req(2'd1, 7'h02, 32'h0, 1, 32'h00002222, 1'b0, 2'd0, 32'h00002222);

    // Reset in the middle of a read, then a late ack that must be ignored.
    r.resp  = 2'd0;
    r.rdata = 32'h0;
    resp_q.push_back(r);
    push_bus(1'b0, 7'h33, 32'h0, 2);
    dmi_op        = 2'd1;
    dmi_addr      = 7'h33;
    dmi_wdata     = 32'h0;
    dmi_req_valid = 1'b1;
    @(posedge clk);
    #1;
    dmi_req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_bus_req", 64'(bus_req), 64'd0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h55AA55AA;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    do_req(2'd0, 7'h00, 32'h0, 0, 32'h0, 1'b0, 2'd0, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("resp_q_empty", 64'(resp_q.size()), 64'd0);
    check("bus_q_empty", 64'(bus_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
